// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relu_pkg
//  Description : Shared lane constants, lane type and ReLU helper for the
//                packed-vector ReLU block.
//  Revision    : 1.0 - initial release
// ============================================================================
package relu_pkg;

  // Width of one independent lane in the packed vectors.
  localparam int LANE_W = 8;

  // One lane, interpreted as a two's-complement signed value.
  typedef logic signed [LANE_W-1:0] lane_t;

  // Rectify one lane: negative values clamp to zero, others pass through.
  function automatic lane_t relu_fn(input lane_t x);
    return x[LANE_W-1] ? lane_t'(0) : x;
  endfunction

endpackage : relu_pkg
`default_nettype wire

// File: rtl/relu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : relu_lane
//  Description : Combinational ReLU of a single signed 8-bit lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_lane
  import relu_pkg::*;
(
  input  lane_t in_i,
  output lane_t out_o
);

  // The sign bit alone selects zero or pass-through.
  assign out_o = relu_fn(in_i);

endmodule : relu_lane
`default_nettype wire

// File: rtl/relu.sv
`default_nettype none
// ============================================================================
//  Module      : relu
//  Description : SIZE parallel 8-bit signed ReLU lanes with a single output
//                register (latency 1, no stall). Asynchronous active-low
//                reset clears the output immediately.
//  Revision    : 1.0 - initial release
// ============================================================================
module relu
  import relu_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LANE_W*SIZE-1:0] in,
  output logic [LANE_W*SIZE-1:0] out
);

  logic [LANE_W*SIZE-1:0] out_d;
  logic [LANE_W*SIZE-1:0] out_q;

  // One combinational lane per byte; lanes never interact.
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    lane_t lane_out;

    relu_lane u_lane (
      .in_i  (lane_t'(in[k*LANE_W +: LANE_W])),
      .out_o (lane_out)
    );

    assign out_d[k*LANE_W +: LANE_W] = lane_out;
  end

  // Output register: cleared asynchronously, otherwise captures every edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : relu
`default_nettype wire

// File: tb/tb_relu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu
//  Description : Self-checking bench for relu at SIZE = 1, 4 and 7.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_relu;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in1,  out1;
  logic [31:0] in4,  out4;
  logic [55:0] in7,  out7;
  logic [55:0] exp1, exp4, exp7;

  int checks = 0;
  int errors = 0;

  relu #(.SIZE(1)) u_d1 (.clock(clk), .reset(rst_n), .in(in1), .out(out1));
  relu #(.SIZE(4)) u_d4 (.clock(clk), .reset(rst_n), .in(in4), .out(out4));
  relu #(.SIZE(7)) u_d7 (.clock(clk), .reset(rst_n), .in(in7), .out(out7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each byte read as a signed number; keep it if >= 0 else 0.
  function automatic logic [55:0] ref_relu(input logic [55:0] v, input int n);
    logic [55:0] r;
    logic signed [7:0] b;
    r = '0;
    for (int k = 0; k < n; k++) begin
      b = v[8*k +: 8];
      if (b >= 0) r[8*k +: 8] = b;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model state: what each output register must hold right now.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp1 = '0; exp4 = '0; exp7 = '0;
    end else begin
      exp1 = ref_relu({48'd0, in1}, 1);
      exp4 = ref_relu({24'd0, in4}, 4);
      exp7 = ref_relu(in7, 7);
    end
  end

  // Compare every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    chk("cyc_s1", {48'd0, out1}, exp1);
    chk("cyc_s4", {24'd0, out4}, exp4);
    chk("cyc_s7", out7,          exp7);
  end

  task automatic drive_random();
    in1 = 8'($urandom);
    in4 = $urandom;
    in7 = {24'($urandom), 32'($urandom)};
  endtask

  initial begin
    rst_n = 1'b1;
    in1 = '0; in4 = '0; in7 = '0;
    exp1 = '0; exp4 = '0; exp7 = '0;

    // Reset takes effect with no clock edge.
    #1 rst_n = 1'b0;
    in4 = 32'hFF80_4020;
    #2;
    chk("rst_async_s4", {24'd0, out4}, 56'd0);
    chk("rst_async_s7", out7, 56'd0);

    // Release reset away from the edge; first edge captures normally.
    @(negedge clk);
    rst_n = 1'b1;
    in1 = 8'h7F;
    in7 = 56'h80_7F_01_FF_00_81_7E;
    @(posedge clk); #1;
    chk("mixed_s4", {24'd0, out4}, 56'h0000_4020);
    chk("mixed_s1", {48'd0, out1}, 56'h7F);
    chk("mixed_s7", out7, 56'h00_7F_01_00_00_00_7E);

    // New input; old result must hold until the next edge.
    @(negedge clk);
    in4 = 32'hF021_0100;
    in1 = 8'h80;
    #1;
    chk("hold_s4", {24'd0, out4}, 56'h0000_4020);
    @(posedge clk); #1;
    chk("next_s4", {24'd0, out4}, 56'h0021_0100);
    chk("next_s1", {48'd0, out1}, 56'h00);

    // Boundary values.
    @(negedge clk);
    in4 = 32'h7F80_00FF;
    in1 = 8'hFF;
    @(posedge clk); #1;
    chk("bound_s4", {24'd0, out4}, 56'h7F00_0000);
    chk("bound_s1", {48'd0, out1}, 56'h00);

    // Randomised stream with periodic mid-stream reset pulses.
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      drive_random();
      if (c % 300 == 150) begin
        in4 = 32'h1234_5678;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_s4", {24'd0, out4}, 56'd0);
        chk("midrst_s7", out7, 56'd0);
        chk("midrst_s1", {48'd0, out1}, 56'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        in4 = 32'h8170_FF05;
        @(posedge clk); #1;
        chk("post_rst_s4", {24'd0, out4}, 56'h0070_0005);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_relu
`default_nettype wire
